video_sync_gen: RTL and testbench

VIDEO_SYNC_GEN -- requirements
Module: video_sync_generator

---
 rtl/video_sync_gen_pkg.sv | 32 +++
 rtl/video_sync_gen_sync_counter.sv | 23 ++
 rtl/video_sync_gen.sv | 52 +++++
 tb/tb_video_sync_gen.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/video_sync_gen_pkg.sv
// video_sync_gen_pkg: default VGA 640x480@60 timing, derived totals/windows and shared types.
package video_sync_gen_pkg;
    localparam int CNT_W = 10;

    localparam int H_VISIBLE_D = 640;
    localparam int H_FRONT_D   = 16;
    localparam int H_SYNC_D    = 96;
    localparam int H_BACK_D    = 48;
    localparam int V_VISIBLE_D = 480;
    localparam int V_FRONT_D   = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BACK_D    = 33;

    localparam int H_TOTAL_D     = H_SYNC_D + H_BACK_D + H_VISIBLE_D + H_FRONT_D;
    localparam int V_TOTAL_D     = V_SYNC_D + V_BACK_D + V_VISIBLE_D + V_FRONT_D;
    localparam int H_ACT_START_D = H_SYNC_D + H_BACK_D;
    localparam int H_ACT_END_D   = H_ACT_START_D + H_VISIBLE_D;
    localparam int V_ACT_START_D = V_SYNC_D + V_BACK_D;
    localparam int V_ACT_END_D   = V_ACT_START_D + V_VISIBLE_D;

    typedef struct packed {
        logic blank_n;
        logic hs;
        logic vs;
    } sync_t;

    localparam sync_t SYNC_RST = '{blank_n: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic logic in_window(input logic [CNT_W-1:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction
endpackage

// File: rtl/video_sync_gen_sync_counter.sv
// sync_counter: modulo-MODULUS counter advancing when en_i is high; wrap_o flags the
// enabled clock on which it returns to zero.
module sync_counter #(
    parameter int MODULUS = 800,
    parameter int W       = 10
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = en_i && (cnt_q == W'(MODULUS - 1));
    assign cnt_d  = wrap_o ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/video_sync_gen.sv
// video_sync_gen: line/frame counters with registered active-low HS/VS and blank_n.
// Line and frame order is sync, back porch, visible, front porch.
module video_sync_gen
    import video_sync_gen_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_D,
    parameter int H_FRONT   = H_FRONT_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BACK    = H_BACK_D,
    parameter int V_VISIBLE = V_VISIBLE_D,
    parameter int V_FRONT   = V_FRONT_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BACK    = V_BACK_D
) (
    input  logic vga_clk,
    input  logic reset,
    output logic blank_n,
    output logic HS,
    output logic VS
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_wrap, v_wrap_unused;
    sync_t            out_d, out_q;

    sync_counter #(.MODULUS(H_TOTAL), .W(CNT_W)) u_h_cnt (
        .clk_i(vga_clk), .rst_n_i(reset), .en_i(1'b1), .cnt_o(h_cnt), .wrap_o(h_wrap)
    );

    sync_counter #(.MODULUS(V_TOTAL), .W(CNT_W)) u_v_cnt (
        .clk_i(vga_clk), .rst_n_i(reset), .en_i(h_wrap), .cnt_o(v_cnt), .wrap_o(v_wrap_unused)
    );

    always_comb begin
        out_d.blank_n = in_window(h_cnt, H_SYNC + H_BACK, H_SYNC + H_BACK + H_VISIBLE) &&
                        in_window(v_cnt, V_SYNC + V_BACK, V_SYNC + V_BACK + V_VISIBLE);
        out_d.hs      = int'(h_cnt) >= H_SYNC;
        out_d.vs      = int'(v_cnt) >= V_SYNC;
    end

    // Outputs come straight from flops so ports never see counter decode glitches.
    always_ff @(posedge vga_clk or negedge reset) begin
        if (!reset) out_q <= SYNC_RST;
        else        out_q <= out_d;
    end

    assign blank_n = out_q.blank_n;
    assign HS      = out_q.hs;
    assign VS      = out_q.vs;
endmodule

// File: tb/tb_video_sync_gen.sv
// tb_video_sync_gen: default-mode and small-mode instances checked every clock against a
// position-based timing model, plus a hand-derived vector table and frame statistics.
module tb_video_sync_gen;
    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
    } mode_t;

    typedef struct {
        int         k;
        logic [2:0] exp;
    } vec_t;

    logic vga_clk = 1'b0;
    logic reset   = 1'b0;
    logic bn_d, hs_d, vs_d, bn_s, hs_s, vs_s;
    int   k;
    int   vectors = 0;
    int   miscompares = 0;
    mode_t m_def, m_small;
    vec_t  tbl[13];

    video_sync_gen u_def (
        .vga_clk(vga_clk), .reset(reset), .blank_n(bn_d), .HS(hs_d), .VS(vs_d)
    );

    video_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .vga_clk(vga_clk), .reset(reset), .blank_n(bn_s), .HS(hs_s), .VS(vs_s)
    );

    always #5 vga_clk = ~vga_clk;

    // Number of rising edges since reset was last released.
    always @(posedge vga_clk or negedge reset) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    // After k edges the outputs reflect raster position k-1, modulo the frame size.
    function automatic logic [2:0] model(input int kk, input mode_t m);
        int ht, vt, p, h, v;
        ht = m.hs + m.hb + m.hv + m.hf;
        vt = m.vs + m.vb + m.vv + m.vf;
        if (kk == 0) return 3'b011;
        p = (kk - 1) % (ht * vt);
        h = p % ht;
        v = p / ht;
        return {(h >= m.hs + m.hb) && (h < m.hs + m.hb + m.hv) &&
                (v >= m.vs + m.vb) && (v < m.vs + m.vb + m.vv),
                h >= m.hs, v >= m.vs};
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s k=%0d got {blank_n,HS,VS}=%b expected %b", name, k, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            if (miscompares <= 20)
                $display("FAIL %s k=%0d got %0d expected %0d", name, k, act, exp);
        end
    endtask

    task automatic check_both();
        check("default", {bn_d, hs_d, vs_d}, model(k, m_def));
        check("small", {bn_s, hs_s, vs_s}, model(k, m_small));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1);
    end

    initial begin
        int n, sb, run_s, hs_low, both_low, hold;
        m_def   = '{hv: 640, hf: 16, hs: 96, hb: 48, vv: 480, vf: 10, vs: 2, vb: 33};
        m_small = '{hv: 8, hf: 1, hs: 2, hb: 1, vv: 4, vf: 1, vs: 1, vb: 1};
        // Small mode: H_TOTAL 12, V_TOTAL 7, visible h 3..10, v 2..5; entries are {blank_n,HS,VS}.
        tbl = '{'{1, 3'b000}, '{2, 3'b000}, '{3, 3'b010}, '{4, 3'b010}, '{12, 3'b010},
                '{13, 3'b001}, '{28, 3'b111}, '{35, 3'b111}, '{36, 3'b011}, '{64, 3'b111},
                '{76, 3'b011}, '{80, 3'b011}, '{85, 3'b000}};

        repeat (3) @(negedge vga_clk);
        check("reset_default", {bn_d, hs_d, vs_d}, 3'b011);
        check("reset_small", {bn_s, hs_s, vs_s}, 3'b011);
        reset = 1'b1;

        foreach (tbl[i]) begin
            n = 0;
            while (k < tbl[i].k && n < 200) begin
                @(negedge vga_clk);
                n++;
            end
            if (k != tbl[i].k) check_int("table_wait", k, tbl[i].k);
            else               check("table", {bn_s, hs_s, vs_s}, tbl[i].exp);
        end

        // Uninterrupted run into line 36 of the default mode, with per-frame/per-line statistics.
        sb = 0; run_s = 0; hs_low = 0; both_low = 0;
        while (k < 36 * 800 + 1) begin
            @(negedge vga_clk);
            check_both();
            if (bn_s) begin
                sb++;
                run_s++;
            end else if (run_s != 0) begin
                check_int("small_run_len", run_s, 8);
                run_s = 0;
            end
            if ((k - 1) % 84 == 83) begin
                check_int("small_frame_visible", sb, 32);
                sb = 0;
            end
            if (k > 800) begin
                hs_low   += int'(!hs_d);
                both_low += int'(!hs_d && !vs_d);
                if ((k - 1) % 800 == 799) begin
                    check_int("default_hs_low", hs_low, 96);
                    check_int("default_hs_vs_low", both_low, ((k - 1) / 800 < 2) ? 96 : 0);
                    hs_low = 0;
                    both_low = 0;
                end
            end
        end

        @(negedge vga_clk);
        reset = 1'b0;
        #1;
        check("abort_default", {bn_d, hs_d, vs_d}, 3'b011);
        check("abort_small", {bn_s, hs_s, vs_s}, 3'b011);
        @(negedge vga_clk);
        reset = 1'b1;

        // Random mid-frame resets of random length.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge vga_clk);
            check_both();
            if (reset && $urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                #1;
                check("async_default", {bn_d, hs_d, vs_d}, 3'b011);
                check("async_small", {bn_s, hs_s, vs_s}, 3'b011);
                hold = int'($urandom_range(1, 3));
            end else if (!reset) begin
                hold--;
                if (hold <= 0) reset = 1'b1;
            end
        end
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
